// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default cause width and the lowest-index priority encoder.
package interrupt_controller_pkg;

  localparam int CAUSE_W_DEF = 3;
  localparam int MAX_IRQ     = 16;  // widest request vector supported
  localparam int IDX_W       = 4;   // clog2(MAX_IRQ)

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2
  } ic_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Lowest set bit wins. The loop walks downward so the last hit is the
  // lowest index.
  function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] vec);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/interrupt_controller_sync_edge.sv
// irq_sync_edge: two-flop synchroniser plus a history flop per line;
// flags a rising edge for one cycle.
//   clk, reset (async active-low), d: raw async lines, rise: edge pulses.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller feeding the PC's acknowledge input.
// Latches rising edges of irq as pending, selects the lowest-index
// pending & masked source when globally enabled and at an instruction
// boundary, pulses inta for one cycle with the cause, then blocks until
// reti (no nesting).
// Ports:
//   clk, reset (async active-low)
//   irq         raw async requests, rising-edge sensitive
//   int_enable  global enable;  stall: no acknowledge this cycle
//   mask_we/mask_in  mask register write (1 = source enabled)
//   reti        return-from-interrupt strobe
//   inta        one-cycle acknowledge;  cause: serviced index
//   pending, mask  register views;  in_service: ack until reti
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int                 NUM_IRQ  = 8,
  parameter int                 CAUSE_W  = CAUSE_W_DEF,
  parameter logic [NUM_IRQ-1:0] MASK_RST = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_enable,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               stall,
  input  logic               reti,
  output logic               inta,
  output logic [CAUSE_W-1:0] cause,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               in_service
);

  ic_state_t          state, state_nxt;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clr;
  prio_t              sel;
  logic               take;

  irq_sync_edge #(.W(NUM_IRQ)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq),
    .rise  (rise)
  );

  // Masked sources still latch pending; the mask only gates selection.
  always_comb begin
    eligible = pending & mask;
    sel      = prio_enc(MAX_IRQ'(eligible));
    take     = (state == IDLE) && int_enable && !stall && sel.valid;
    ack_clr  = take ? (NUM_IRQ'(1) << sel.idx) : '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = ACK;
      ACK:     state_nxt = SERVICE;
      SERVICE: if (reti) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= '0;
      mask       <= MASK_RST;
      cause      <= '0;
      in_service <= 1'b0;
    end else begin
      state   <= state_nxt;
      // A new edge on the bit being acknowledged survives the clear.
      pending <= (pending & ~ack_clr) | rise;
      if (mask_we) mask <= mask_in;
      if (take) begin
        cause      <= CAUSE_W'(sel.idx);
        in_service <= 1'b1;
      end else if (state == SERVICE && reti) begin
        in_service <= 1'b0;
      end
    end
  end

  assign inta = (state == ACK);

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int N = 8;
  localparam int P_IDLE = 0, P_ACK = 1, P_SVC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq = '0;
  logic         int_enable = 1'b0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_in = '0;
  logic         stall = 1'b0;
  logic         reti = 1'b0;
  logic         inta;
  logic [2:0]   cause;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic         in_service;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.NUM_IRQ(N), .CAUSE_W(3), .MASK_RST(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .int_enable (int_enable),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .stall      (stall),
    .reti       (reti),
    .inta       (inta),
    .cause      (cause),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h1/h2/h3: irq as sampled 1, 2 and 3 clock edges ago. A source's edge
  // becomes visible once it has been seen high two edges back but low
  // three edges back.
  logic [N-1:0] m_pend = '0, m_mask = '0, h1 = '0, h2 = '0, h3 = '0;
  logic [2:0]   m_cause = '0;
  logic         m_insvc = 1'b0;
  int           m_phase = P_IDLE;

  logic [N-1:0] n_pend, clr, elig;
  logic [2:0]   n_cause;
  logic         n_insvc;
  int           n_phase;
  int           pick;

  always_comb begin
    clr     = '0;
    n_cause = m_cause;
    n_insvc = m_insvc;
    n_phase = m_phase;
    pick    = 0;
    elig    = m_pend & m_mask;
    if (m_phase == P_IDLE) begin
      if (int_enable && !stall && elig != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (elig[i]) pick = i;
        clr[pick] = 1'b1;
        n_cause   = 3'(pick);
        n_insvc   = 1'b1;
        n_phase   = P_ACK;
      end
    end else if (m_phase == P_ACK) begin
      n_phase = P_SVC;
    end else if (reti) begin
      n_phase = P_IDLE;
      n_insvc = 1'b0;
    end
    n_pend = (m_pend & ~clr) | (h2 & ~h3);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= '0; m_mask <= '0; m_cause <= '0; m_insvc <= 1'b0;
      m_phase <= P_IDLE; h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      m_pend  <= n_pend;
      m_cause <= n_cause;
      m_insvc <= n_insvc;
      m_phase <= n_phase;
      if (mask_we) m_mask <= mask_in;
      h1 <= irq; h2 <= h1; h3 <= h2;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_inta",    32'(inta),       32'(m_phase == P_ACK));
      chk("m_cause",   32'(cause),      32'(m_cause));
      chk("m_pending", 32'(pending),    32'(m_pend));
      chk("m_mask",    32'(mask),       32'(m_mask));
      chk("m_insvc",   32'(in_service), 32'(m_insvc));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick(3);
    #1 reset = 1'b1;
    tick(1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_inta", 32'(inta), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_insvc", 32'(in_service), 0);

    // Single source, latency
    mask_we = 1; mask_in = 8'hFF; int_enable = 1;
    tick(1);
    mask_we = 0;
    chk("t2_mask", 32'(mask), 32'hFF);
    irq = 8'h20;
    tick(2);
    chk("t2_pend_early", 32'(pending), 0);
    tick(1);
    chk("t2_pend", 32'(pending), 32'h20);
    chk("t2_inta_early", 32'(inta), 0);
    tick(1);
    chk("t2_inta", 32'(inta), 1);
    chk("t2_cause", 32'(cause), 5);
    chk("t2_pend_clr", 32'(pending), 0);
    chk("t2_insvc", 32'(in_service), 1);
    irq = 0;
    tick(1);
    chk("t2_inta_pulse", 32'(inta), 0);
    chk("t2_insvc_hold", 32'(in_service), 1);
    tick(2);
    reti = 1;
    tick(1);
    reti = 0;
    chk("t2_reti", 32'(in_service), 0);

    // Two simultaneous sources
    irq = 8'h44;
    tick(4);
    chk("t3_inta", 32'(inta), 1);
    chk("t3_cause", 32'(cause), 2);
    chk("t3_pend", 32'(pending), 32'h40);
    irq = 0;
    tick(1);
    reti = 1;
    tick(1);
    reti = 0;
    chk("t3_idle_gap", 32'(inta), 0);
    chk("t3_insvc_gap", 32'(in_service), 0);
    tick(1);
    chk("t3_inta2", 32'(inta), 1);
    chk("t3_cause2", 32'(cause), 6);
    chk("t3_pend2", 32'(pending), 0);
    tick(1);
    reti = 1;
    tick(1);
    reti = 0;

    // Masked source latches but is not serviced until unmasked
    mask_we = 1; mask_in = 8'hFB;
    tick(1);
    mask_we = 0;
    irq = 8'h04;
    tick(5);
    chk("t4_pend", 32'(pending), 32'h04);
    chk("t4_noack", 32'(inta), 0);
    irq = 0;
    mask_we = 1; mask_in = 8'hFF;
    tick(1);
    mask_we = 0;
    chk("t4_mask", 32'(mask), 32'hFF);
    chk("t4_noack2", 32'(inta), 0);
    tick(1);
    chk("t4_inta", 32'(inta), 1);
    chk("t4_cause", 32'(cause), 2);
    tick(1);
    reti = 1;
    tick(1);
    reti = 0;

    // Stall holds off the acknowledge
    stall = 1;
    irq = 8'h08;
    tick(3);
    chk("t5_pend", 32'(pending), 32'h08);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t5_stalled", 32'(inta), 0);
    end
    stall = 0;
    tick(1);
    chk("t5_inta", 32'(inta), 1);
    chk("t5_cause", 32'(cause), 3);
    irq = 8'h01;
    tick(3);
    chk("t6_svc_pend", 32'(pending), 32'h01);
    chk("t6_svc", 32'(in_service), 1);

    // Asynchronous reset during SERVICE
    #2 reset = 1'b0;
    irq = 0;
    #1;
    chk("t6_pending", 32'(pending), 0);
    chk("t6_mask", 32'(mask), 0);
    chk("t6_cause", 32'(cause), 0);
    chk("t6_insvc", 32'(in_service), 0);
    chk("t6_inta", 32'(inta), 0);
    tick(1);
    #1 reset = 1'b1;
    tick(1);
    mask_we = 1; mask_in = 8'hFF;
    tick(1);
    mask_we = 0;
    irq = 8'h02;
    tick(4);
    chk("t6_inta_after", 32'(inta), 1);
    chk("t6_cause_after", 32'(cause), 1);
    irq = 0;
    tick(1);
    reti = 1;
    tick(1);
    reti = 0;

    // Randomised traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if (c == 1500) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      int_enable = ($urandom_range(9) != 0);
      stall      = ($urandom_range(3) == 0);
      reti       = ($urandom_range(4) == 0);
      mask_we    = ($urandom_range(19) == 0);
      mask_in    = 8'($urandom);
    end
    tick(1);
    reti = 0; mask_we = 0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
